addsub_accum_pipe: RTL and testbench
====================================

ADDSUB_ACCUM_PIPE -- requirements
Module: addsub_accum_pipe

Interface
REQ-001: Parameter WIDTH, default 8, operand/result width, legal 2..32.
REQ-002: Parameter SATURATE, default 0, 1 = clamp signed overflow results to the signed extreme.
REQ-003: Clock  input  1  sole clock, all state updates on rising edge.
REQ-004: Reset  input  1  synchronous, active-high reset.
REQ-005: in_valid  input  1  request carries a valid operation.
REQ-006: in_ready  output  1  block accepts a request this cycle.
REQ-007: op  input  2  operation: 00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A.
REQ-008: A  input  WIDTH  first operand, two's complement.
REQ-009: B  input  WIDTH  second operand, ignored for op 10/11.
REQ-010: clr_sticky  input  1  clears sticky overflow flag.
REQ-011: out_valid  output  1  S/carry/overflow hold a valid result.
REQ-012: out_ready  input  1  consumer takes the result this cycle.
REQ-013: S  output  WIDTH  result.
REQ-014: carry  output  1  unsigned carry out of the MSB; for subtraction 1 = no borrow.
REQ-015: overflow  output  1  signed overflow of this result.
REQ-016: sticky_ovf  output  1  set by any delivered overflow, held until cleared.

Function
REQ-017: The block SHALL be a two-stage pipeline: stage 1 registers {op, A, B}; stage 2 computes and registers {S, carry, overflow}.
REQ-018: A request SHALL be accepted on a cycle with in_valid=1 and in_ready=1; the result SHALL appear with out_valid=1 two cycles later when no backpressure exists.
REQ-019: Stage 2 SHALL load when out_valid=0 or out_ready=1; stage 1 SHALL load when it is empty or stage 2 loads; in_ready SHALL equal that stage-1 load condition.
REQ-020: Under out_ready=0 the block SHALL hold two requests; no request is dropped, duplicated or reordered.
REQ-021: Outputs S, carry, overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022: Subtraction SHALL be computed as X + ~Y + 1 on the same WIDTH-bit ripple adder.
REQ-023: overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-024: With SATURATE=1 and overflow=1, S SHALL be 0 followed by all 1s (max positive) if the first operand is non-negative, else 1 followed by all 0s (min negative); carry and overflow still report the raw sum.
REQ-025: The accumulator ACC (WIDTH bits, internal) SHALL take the final S of every op when stage 2 loads, so ops 00/01 seed the accumulator.
REQ-026: Consecutive accumulate ops in the pipeline SHALL use the ACC produced by the immediately preceding op (forwarding from stage 2); results SHALL equal strict sequential evaluation.
REQ-027: sticky_ovf SHALL set on the cycle stage 2 loads a result with overflow=1; clr_sticky=1 clears it; simultaneous set and clear SHALL leave it set.
REQ-028: WIDTH wrap-around SHALL be modulo 2^WIDTH when SATURATE=0.

Reset
REQ-029: On Clock edge with Reset=1: both stage-valid bits, out_valid, S, carry, overflow, sticky_ovf and ACC SHALL become 0; in_ready SHALL be 1 the following cycle.
REQ-030: Reset SHALL override all concurrent requests; in-flight requests are discarded.

Structure
REQ-031: Op codes (OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB) SHALL live in a shared constants include file used by RTL and bench.
REQ-032: The adder SHALL be a separate parametrised sub-module ripple_adder_n (WIDTH, cin, sum, carry into MSB, carry out) built from full-adder cells via generate.

Verification (WIDTH=8)
REQ-033: op=00, A=0x7F, B=0x01 -> S=0x80, carry=0, overflow=1, sticky_ovf=1; with SATURATE=1 S=0x7F.
REQ-034: op=01, A=0x05, B=0x07 -> S=0xFE, carry=0, overflow=0; op=01, A=0x80, B=0x01 -> S=0x7F, overflow=1.
REQ-035: back-to-back op=00 A=0x10 B=0x00, op=10 A=0x20, op=11 A=0x05 -> S=0x10, 0x30, 0x2B on consecutive cycles.
REQ-036: out_ready=0, three requests offered -> two accepted, in_ready=0 thereafter; on out_ready=1 results emerge in order, third then accepted.
REQ-037: Reset asserted with two requests in flight -> next cycle out_valid=0, sticky_ovf=0; subsequent op=10 A=0x01 -> S=0x01.
REQ-038: clr_sticky=1 on the same cycle an overflow result loads -> sticky_ovf=1; clr_sticky=1 alone next -> sticky_ovf=0.

Source files
------------

// File: rtl/addsub_accum_pipe_pkg.sv
// addsub_accum_pipe_pkg: op codes and decode helpers shared by RTL and testbench
package addsub_accum_pipe_pkg;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;
    function automatic logic is_acc(input logic [1:0] op);
        return op[1];
    endfunction
    function automatic logic is_sub(input logic [1:0] op);
        return op[0];
    endfunction
endpackage

// File: rtl/addsub_accum_pipe_adder.sv
// addsub_accum_pipe_adder: full-adder cell and the ripple_adder_n chain built from it
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module ripple_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             c_msb,
    output logic             cout
);
    logic [WIDTH:0] c;
    assign c[0] = cin;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (.x(x[i]), .y(y[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
        end
    endgenerate
    assign c_msb = c[WIDTH-1];
    assign cout  = c[WIDTH];
endmodule

// File: rtl/addsub_accum_pipe.sv
// addsub_accum_pipe: two-stage add/sub/accumulate pipeline with valid/ready handshake
module addsub_accum_pipe
    import addsub_accum_pipe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             overflow,
    output logic             sticky_ovf
);
    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_next;
    logic             c_msb;
    logic             cout;
    logic             ovf;
    logic             s2_load;
    logic             s2_take;
    assign s2_load  = !out_valid || out_ready;
    assign s2_take  = s2_load && s1_valid;
    assign in_ready = !s1_valid || s2_load;
    // acc always holds the previous op's result, so back-to-back accumulates see it directly
    assign x = is_acc(s1_op) ? acc : s1_a;
    assign y = is_acc(s1_op) ? s1_a : s1_b;
    ripple_adder_n #(.WIDTH(WIDTH)) u_add (
        .x(x),
        .y(is_sub(s1_op) ? ~y : y),
        .cin(is_sub(s1_op)),
        .sum(sum),
        .c_msb(c_msb),
        .cout(cout)
    );
    assign ovf    = c_msb ^ cout;
    assign s_next = (SATURATE && ovf) ? {x[WIDTH-1], {(WIDTH-1){~x[WIDTH-1]}}} : sum;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            out_valid  <= 1'b0;
            s          <= '0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            acc        <= '0;
            sticky_ovf <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                s1_op    <= op;
                s1_a     <= a;
                s1_b     <= b;
            end
            if (s2_load) out_valid <= s1_valid;
            if (s2_take) begin
                s        <= s_next;
                carry    <= cout;
                overflow <= ovf;
                acc      <= s_next;
            end
            if (s2_take && ovf) sticky_ovf <= 1'b1;
            else if (clr_sticky) sticky_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_accum_pipe.sv
// tb_addsub_accum_pipe: directed vectors plus handshake, reset and sticky sequences
module tb_addsub_accum_pipe;
    import addsub_accum_pipe_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] op = OP_ADD;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       clr_sticky = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, carry, overflow, sticky_ovf;
    logic [7:0] s;
    logic       in_ready_sat, out_valid_sat, carry_sat, overflow_sat, sticky_sat;
    logic [7:0] s_sat;
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
        logic       o;
        logic [7:0] ss;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    addsub_accum_pipe #(.WIDTH(8), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .clr_sticky(clr_sticky), .out_valid(out_valid), .out_ready(out_ready), .s(s),
        .carry(carry), .overflow(overflow), .sticky_ovf(sticky_ovf)
    );
    addsub_accum_pipe #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sat), .op(op), .a(a), .b(b),
        .clr_sticky(clr_sticky), .out_valid(out_valid_sat), .out_ready(out_ready), .s(s_sat),
        .carry(carry_sat), .overflow(overflow_sat), .sticky_ovf(sticky_sat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        in_valid = v;
        op = o;
        a = x;
        b = y;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{OP_ADD,     8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 8'h7F};
        vecs[1]  = '{OP_SUB,     8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 8'hFE};
        vecs[2]  = '{OP_SUB,     8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 8'h80};
        vecs[3]  = '{OP_ADD,     8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 8'h10};
        vecs[4]  = '{OP_ACC_ADD, 8'h20, 8'hAA, 8'h30, 1'b0, 1'b0, 8'h30};
        vecs[5]  = '{OP_ACC_SUB, 8'h05, 8'h55, 8'h2B, 1'b1, 1'b0, 8'h2B};
        vecs[6]  = '{OP_ADD,     8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{OP_ACC_ADD, 8'h7F, 8'h00, 8'h7F, 1'b0, 1'b0, 8'h7F};
        vecs[8]  = '{OP_ACC_ADD, 8'h01, 8'h00, 8'h80, 1'b0, 1'b1, 8'h7F};
        vecs[9]  = '{OP_ADD,     8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 8'h80};
        vecs[10] = '{OP_SUB,     8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 8'hFF};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            drive(1'b0, OP_ADD, 8'h00, 8'h00);
            wait_out($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].s));
            chk($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].c));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].o));
            chk($sformatf("vec%0d_sat_s", i), 32'(s_sat), 32'(vecs[i].ss));
            chk($sformatf("vec%0d_sat_ovf", i), 32'(overflow_sat), 32'(vecs[i].o));
            if (i == 0) chk("vec0_sticky", 32'(sticky_ovf), 32'd1);
        end
        @(negedge clk);

        // back-to-back seed and accumulate, one result per cycle
        drive(1'b1, OP_ADD, 8'h10, 8'h00);
        @(negedge clk);
        drive(1'b1, OP_ACC_ADD, 8'h20, 8'h00);
        @(negedge clk);
        chk("b2b0_valid", 32'(out_valid), 32'd1);
        chk("b2b0_s", 32'(s), 32'h10);
        drive(1'b1, OP_ACC_SUB, 8'h05, 8'h00);
        @(negedge clk);
        chk("b2b1_valid", 32'(out_valid), 32'd1);
        chk("b2b1_s", 32'(s), 32'h30);
        drive(1'b0, OP_ADD, 8'h00, 8'h00);
        @(negedge clk);
        chk("b2b2_valid", 32'(out_valid), 32'd1);
        chk("b2b2_s", 32'(s), 32'h2B);
        @(negedge clk);
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // backpressure: two held, third waits, order preserved
        out_ready = 1'b0;
        chk("bp_ready0", 32'(in_ready), 32'd1);
        drive(1'b1, OP_ADD, 8'h01, 8'h02);
        @(negedge clk);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        drive(1'b1, OP_ADD, 8'h10, 8'h20);
        @(negedge clk);
        chk("bp_ready2", 32'(in_ready), 32'd0);
        chk("bp_valid2", 32'(out_valid), 32'd1);
        chk("bp_s2", 32'(s), 32'h03);
        drive(1'b1, OP_ACC_ADD, 8'h05, 8'h00);
        @(negedge clk);
        chk("bp_ready3", 32'(in_ready), 32'd0);
        chk("bp_hold3", 32'(s), 32'h03);
        @(negedge clk);
        chk("bp_hold4", 32'(s), 32'h03);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_r2_valid", 32'(out_valid), 32'd1);
        chk("bp_r2_s", 32'(s), 32'h30);
        drive(1'b0, OP_ADD, 8'h00, 8'h00);
        @(negedge clk);
        chk("bp_r3_valid", 32'(out_valid), 32'd1);
        chk("bp_r3_s", 32'(s), 32'h35);
        @(negedge clk);
        chk("bp_drain", 32'(out_valid), 32'd0);

        // reset with requests in flight and one offered concurrently
        drive(1'b1, OP_ADD, 8'h7F, 8'h01);
        @(negedge clk);
        drive(1'b0, OP_ADD, 8'h00, 8'h00);
        wait_out("pre_rst");
        chk("pre_rst_sticky", 32'(sticky_ovf), 32'd1);
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 8'h01, 8'h01);
        @(negedge clk);
        drive(1'b1, OP_ADD, 8'h02, 8'h02);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, OP_ADD, 8'h03, 8'h03);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, OP_ADD, 8'h00, 8'h00);
        out_ready = 1'b1;
        chk("rst_fl_valid", 32'(out_valid), 32'd0);
        chk("rst_fl_sticky", 32'(sticky_ovf), 32'd0);
        chk("rst_fl_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_fl_discard", 32'(out_valid), 32'd0);
        drive(1'b1, OP_ACC_ADD, 8'h01, 8'h00);
        @(negedge clk);
        drive(1'b0, OP_ADD, 8'h00, 8'h00);
        wait_out("post_rst");
        chk("post_rst_s", 32'(s), 32'h01);
        @(negedge clk);

        // sticky: clear coincident with overflow load keeps it set
        drive(1'b1, OP_ADD, 8'h7F, 8'h01);
        @(negedge clk);
        drive(1'b0, OP_ADD, 8'h00, 8'h00);
        clr_sticky = 1'b1;
        @(negedge clk);
        chk("stk_ovf", 32'(overflow), 32'd1);
        chk("stk_set_wins", 32'(sticky_ovf), 32'd1);
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("stk_cleared", 32'(sticky_ovf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
